prebuf_line_ring: RTL

Parametrised multi-line ring buffer for the pre-buffer stage. It accepts a raster pixel stream and stores the last NUM_LINES-1 lines in NUM_LINES-1 block-RAM banks of LINE_WIDTH words each. For every accepted pixel it emits one registered vertical column of NUM_LINES pixels: the new pixel plus the pixels at the same column in the preceding lines. It succeeds the single-bank pre-buffer RAM and feeds the downstream window/filter logic.

---
 rtl/prebuf_line_ring.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/prebuf_line_ring.sv
// prebuf_line_ring: multi-line ring buffer for the pre-buffer stage.
// Stores the last NUM_LINES-1 raster lines in separate block-RAM banks and,
// for every accepted pixel, presents a vertical column of NUM_LINES pixels
// (new pixel in slice 0, older lines in higher slices) one cycle later.
module prebuf_line_ring #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned LINE_WIDTH = 1920,
  parameter int unsigned NUM_LINES  = 3,
  parameter int unsigned AWIDTH     = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  output logic                          out_valid,
  output logic [NUM_LINES*DWIDTH-1:0]   out_data,
  output logic [AWIDTH-1:0]             out_col,
  output logic                          out_eol,
  output logic                          primed
);

  localparam int unsigned NB     = NUM_LINES - 1;
  localparam int unsigned BW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned FW     = $clog2(NUM_LINES);
  localparam int unsigned RAM_AW = $clog2(LINE_WIDTH);

  localparam logic [AWIDTH-1:0] LAST_COL  = AWIDTH'(LINE_WIDTH - 1);
  localparam logic [BW-1:0]     LAST_BANK = BW'(NB - 1);
  localparam logic [FW-1:0]     FULL      = FW'(NB);

  logic [AWIDTH-1:0] col;
  logic [BW-1:0]     wr_bank;
  logic [FW-1:0]     fill_cnt;

  // Effective counters for this cycle: frame_start restarts at row 0, col 0.
  logic [AWIDTH-1:0] col_a;
  logic [BW-1:0]     bank_a;
  logic [FW-1:0]     fill_a;
  logic              wrap;
  logic              primed_a;
  logic [AWIDTH-1:0] col_nxt;
  logic [BW-1:0]     bank_nxt;
  logic [FW-1:0]     fill_nxt;
  logic              accept;

  // Bank read data, one DWIDTH slice per bank.
  logic [NB*DWIDTH-1:0] rd_bus;

  // Column side registers captured at accept time.
  logic [DWIDTH-1:0] pix_d;
  logic [BW-1:0]     bank_d;

  assign accept = in_valid & ~rst;

  // Effective position and counter advance for an accepted pixel.
  always_comb begin
    col_a    = col;
    bank_a   = wr_bank;
    fill_a   = fill_cnt;
    if (frame_start) begin
      col_a  = '0;
      bank_a = '0;
      fill_a = '0;
    end
    wrap     = (col_a == LAST_COL);
    primed_a = (fill_a == FULL);
    col_nxt  = wrap ? '0 : col_a + AWIDTH'(1);
    bank_nxt = bank_a;
    fill_nxt = fill_a;
    if (wrap) begin
      bank_nxt = (bank_a == LAST_BANK) ? '0 : bank_a + BW'(1);
      if (fill_a != FULL) begin
        fill_nxt = fill_a + FW'(1);
      end
    end
  end

  // Position, bank and fill counters; frame_start alone also restarts them.
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      wr_bank  <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else if (in_valid) begin
      col      <= col_nxt;
      wr_bank  <= bank_nxt;
      fill_cnt <= fill_nxt;
      primed   <= (fill_nxt == FULL);
    end else if (frame_start) begin
      col      <= '0;
      wr_bank  <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [LINE_WIDTH];
    logic [DWIDTH-1:0] q;

    // Line store write port: only the current write bank takes the pixel.
    always_ff @(posedge clk) begin
      if (accept && (bank_a == BW'(b))) begin
        mem[col_a[RAM_AW-1:0]] <= in_data;
      end
    end

    // Registered read-first port; holds while no pixel is accepted.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (in_valid) begin
        q <= mem[col_a[RAM_AW-1:0]];
      end
    end

    assign rd_bus[b*DWIDTH +: DWIDTH] = q;
  end

  // Output qualifiers and column side data, registered with the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_eol   <= 1'b0;
      pix_d     <= '0;
      bank_d    <= '0;
    end else if (in_valid) begin
      out_valid <= primed_a;
      out_col   <= col_a;
      out_eol   <= wrap;
      pix_d     <= in_data;
      bank_d    <= bank_a;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Column assembly: slice k comes from bank (bank_d - k) mod NB.
  always_comb begin
    int sel;
    out_data             = '0;
    out_data[DWIDTH-1:0] = pix_d;
    for (int k = 1; k < int'(NUM_LINES); k++) begin
      sel = (int'(bank_d) + int'(NB) - k) % int'(NB);
      out_data[k*DWIDTH +: DWIDTH] = rd_bus[sel*DWIDTH +: DWIDTH];
    end
  end

endmodule
